adc_spi_reader: RTL and testbench

//  Upstream of the ExtADC sensor app: serial-ADC front end producing its AdcValue_i/AdcDone_i.
//  - On a start request, runs one SPI read frame on an external serial ADC.
//  - Presents the 16-bit result with a 4-phase start/done handshake.
//  - Sits between the reconfigurable module's AdcDoConvert/AdcConvComplete/AdcValue ports and the pads.

---
 rtl/adc_spi_pkg.sv | 32 +++
 rtl/adc_spi_clkgen.sv | 41 ++++
 rtl/adc_spi_reader.sv | 168 ++++++++++++++++
 tb/tb_adc_spi_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the serial-ADC reader: FSM state encoding, default
// parameter values and the counter-width helper.
// ADC_SPI_AVG_EN (optional) adds the accumulator width used by 4-frame averaging.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_DONE
  } state_t;

  localparam int unsigned DEF_SCLK_DIV   = 4;
  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_LEAD_BITS  = 0;
  localparam int unsigned DEF_DATA_BITS  = 16;
  localparam int unsigned DEF_CS_SETUP   = 2;

  localparam int unsigned VALUE_W = 16;

`ifdef ADC_SPI_AVG_EN
  // Four 16-bit results summed without overflow.
  localparam int unsigned ACC_W = 18;
`endif

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_spi_clkgen.sv
// SCLK generator: divides Clk_i into SCLK half-periods of SCLK_DIV cycles.
// rise/fall are high in the cycle whose closing edge drives SCLK 0->1 / 1->0,
// so the consumer acts on exactly that edge. Held idle-low while en is low.
module adc_spi_clkgen
  import adc_spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned          DIV_W    = cnt_width(SCLK_DIV);
  localparam logic [DIV_W-1:0]     LAST_DIV = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             half_end;

  assign half_end = en && (div_cnt == LAST_DIV);
  assign rise     = half_end && !sclk;
  assign fall     = half_end && sclk;

  // Count out each half-period and toggle SCLK at its end; park low when disabled.
  always_ff @(posedge Clk_i) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (Reset_i || !en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_cnt == LAST_DIV) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial-ADC front end: one SPI mode-0 read frame per start request, result
// presented with a 4-phase start/done handshake.
// Define ADC_SPI_AVG_EN to run four frames per request and report their
// truncated mean; otherwise a single frame is read.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV   = DEF_SCLK_DIV,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned LEAD_BITS  = DEF_LEAD_BITS,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned CS_SETUP   = DEF_CS_SETUP
) (
  input  logic               Clk_i,
  input  logic               Reset_i,
  input  logic               AdcStart_i,
  output logic               AdcDone_o,
  output logic [VALUE_W-1:0] AdcValue_o,
  output logic               Busy_o,
  output logic               SpiCs_n_o,
  output logic               SpiSclk_o,
  input  logic               SpiMiso_i
);

  localparam int unsigned        BIT_W      = cnt_width(FRAME_BITS);
  localparam int unsigned        SETUP_W    = cnt_width(CS_SETUP);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [SETUP_W-1:0] LAST_SETUP = SETUP_W'(CS_SETUP - 1);
  localparam logic [BIT_W:0]     LEAD_EXT   = (BIT_W + 1)'(LEAD_BITS);
  localparam logic [BIT_W:0]     END_EXT    = (BIT_W + 1)'(LEAD_BITS + DATA_BITS);

  state_t               state;
  logic [SETUP_W-1:0]   setup_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W:0]       bit_pos;
  logic                 in_data;
  logic [VALUE_W-1:0]   shreg;
  logic [VALUE_W-1:0]   value;
  logic                 cs_n;
  logic                 done;
  logic                 busy;
  logic                 sclk;
  logic                 sclk_rise;
  logic                 sclk_fall;

`ifdef ADC_SPI_AVG_EN
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [1:0]           frame_cnt;

  assign acc_sum = acc + {{(ACC_W - VALUE_W){1'b0}}, shreg};
`endif

  // 1-based index of the bit being clocked; data window is (LEAD, LEAD+DATA].
  assign bit_pos = {1'b0, bit_cnt} + (BIT_W + 1)'(1);
  assign in_data = (bit_pos > LEAD_EXT) && (bit_pos <= END_EXT);

  adc_spi_clkgen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .en      (state == S_SHIFT),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  // Frame sequencer with registered handshake and chip-select outputs.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state     <= S_IDLE;
      cs_n      <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
      value     <= '0;
      setup_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
`ifdef ADC_SPI_AVG_EN
      acc       <= '0;
      frame_cnt <= '0;
`endif
    end else begin
      // Done rises one cycle after entering DONE and falls on the edge that
      // sees start low, so an already-low start gives a single-cycle pulse.
      done <= (state == S_DONE) && (AdcStart_i || !done);

      case (state)
        S_IDLE: begin
          if (AdcStart_i) begin
            state     <= S_SETUP;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            setup_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
          end
        end

        S_SETUP: begin
          if (setup_cnt == LAST_SETUP) begin
            state <= S_SHIFT;
          end else begin
            setup_cnt <= setup_cnt + SETUP_W'(1);
          end
        end

        S_SHIFT: begin
          // MISO is taken on the same edge that raises SCLK.
          if (sclk_rise && in_data) begin
            shreg <= {shreg[VALUE_W-2:0], SpiMiso_i};
          end
          if (sclk_fall) begin
            if (bit_cnt == LAST_BIT) begin
              state <= S_TAIL;
              cs_n  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        S_TAIL: begin
`ifdef ADC_SPI_AVG_EN
          if (frame_cnt == 2'd3) begin
            value     <= VALUE_W'(acc_sum >> 2);
            acc       <= '0;
            frame_cnt <= '0;
            state     <= S_DONE;
          end else begin
            acc       <= acc_sum;
            frame_cnt <= frame_cnt + 2'd1;
            state     <= S_SETUP;
            cs_n      <= 1'b0;
            setup_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
          end
`else
          value <= shreg;
          state <= S_DONE;
`endif
        end

        S_DONE: begin
          if (!AdcStart_i) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign AdcDone_o  = done;
  assign AdcValue_o = value;
  assign Busy_o     = busy;
  assign SpiCs_n_o  = cs_n;
  assign SpiSclk_o  = sclk;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: a behavioural mode-0 ADC serves known
// words; latency, SCLK count, CS windows, handshake and results are compared
// against hand-computed values. With ADC_SPI_AVG_EN the averaging path is run.
`timescale 1ns/1ps
module tb_adc_spi_reader;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        start2 = 1'b0;
  logic        miso   = 1'b0;
  logic        miso2  = 1'b0;
  logic        done, busy, cs_n, sclk;
  logic        done2, busy2, cs2_n, sclk2;
  logic [15:0] value, value2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_spi_reader dut (
    .Clk_i      (clk),
    .Reset_i    (rst),
    .AdcStart_i (start),
    .AdcDone_o  (done),
    .AdcValue_o (value),
    .Busy_o     (busy),
    .SpiCs_n_o  (cs_n),
    .SpiSclk_o  (sclk),
    .SpiMiso_i  (miso)
  );

  adc_spi_reader #(
    .FRAME_BITS (16),
    .LEAD_BITS  (4),
    .DATA_BITS  (12)
  ) dut_lead (
    .Clk_i      (clk),
    .Reset_i    (rst),
    .AdcStart_i (start2),
    .AdcDone_o  (done2),
    .AdcValue_o (value2),
    .Busy_o     (busy2),
    .SpiCs_n_o  (cs2_n),
    .SpiSclk_o  (sclk2),
    .SpiMiso_i  (miso2)
  );

  // ADC model for dut: new word per CS fall, MSB first, next bit after each SCLK fall.
  logic [15:0] words [8];
  int          nfr    = 0;
  int          rises  = 0;
  int          cs_bad = 0;
  logic [15:0] cur    = '0;
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      cur  = words[nfr[2:0]];
      nfr  = nfr + 1;
      miso = cur[15];
      cur  = cur << 1;
    end else if (prev_sclk && !sclk && !cs_n) begin
      miso = cur[15];
      cur  = cur << 1;
    end
    if (!prev_sclk && sclk) begin
      rises = rises + 1;
      if (cs_n) cs_bad = cs_bad + 1;
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  // ADC model for dut_lead: always serves 0x0ABC.
  logic [15:0] cur2       = '0;
  logic        prev_cs2   = 1'b1;
  logic        prev_sclk2 = 1'b0;

  always @(negedge clk) begin
    if (prev_cs2 && !cs2_n) begin
      cur2  = 16'h0ABC;
      miso2 = cur2[15];
      cur2  = cur2 << 1;
    end else if (prev_sclk2 && !sclk2 && !cs2_n) begin
      miso2 = cur2[15];
      cur2  = cur2 << 1;
    end
    prev_cs2   = cs2_n;
    prev_sclk2 = sclk2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges from the call until done (unit 0) or done2 (unit 1) is seen.
  task automatic wait_done(input int unit_sel, input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge clk);
      edges = edges + 1;
      @(negedge clk);
      if ((unit_sel == 0) ? done : done2) break;
    end
  endtask

  // Raise start at a negedge; the following edge is E0. Returns edges after E0.
  task automatic start_and_wait(input int budget, output int edges);
    start = 1'b1;
    @(posedge clk);
    wait_done(0, budget, edges);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, r0, f0, hi, lows, k;
    for (int i = 0; i < 8; i++) words[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_cs_n",  cs_n,  1);
    check("rst_sclk",  sclk,  0);
    check("rst_done",  done,  0);
    check("rst_busy",  busy,  0);
    check("rst_value", value, 0);
    rst = 1'b0;
    step();

`ifdef ADC_SPI_AVG_EN
    // Four frames 100..103 -> mean 101.
    for (int i = 0; i < 4; i++) begin
      k = nfr + i;
      words[k[2:0]] = 16'(100 + i);
    end
    f0 = nfr;
    start_and_wait(1000, e);
    start = 1'b0;
    check("avg_latency", e, 525);
    check("avg_cs_windows", nfr - f0, 4);
    check("avg_value", value, 101);
    step();
    check("avg_done_clear", done, 0);

    // All-ones frames must not overflow.
    for (int i = 0; i < 4; i++) begin
      k = nfr + i;
      words[k[2:0]] = 16'hFFFF;
    end
    f0 = nfr;
    start_and_wait(1000, e);
    start = 1'b0;
    check("avg_max_value", value, 16'hFFFF);
    check("avg_max_windows", nfr - f0, 4);
    step();

    start2 = 1'b1;
    @(posedge clk);
    wait_done(1, 1000, e);
    start2 = 1'b0;
    check("avg_lead_value", value2, 16'h0ABC);
    step();
`else
    // 1: start held until done.
    words[nfr[2:0]] = 16'hA5C3;
    r0 = rises;
    f0 = nfr;
    start_and_wait(300, e);
    start = 1'b0;
    check("t1_latency", e, 132);
    check("t1_value", value, 16'hA5C3);
    check("t1_sclk_rises", rises - r0, 16);
    check("t1_cs_windows", nfr - f0, 1);
    check("t1_cs_low_at_rises", cs_bad, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_done_clear", done, 0);

    // 2: start held 500 cycles after done -> no second frame.
    words[nfr[2:0]] = 16'h1234;
    f0 = nfr;
    start_and_wait(300, e);
    check("t2_value", value, 16'h1234);
    lows = 0;
    repeat (500) begin
      step();
      if (!done) lows = lows + 1;
    end
    check("t2_done_held", lows, 0);
    check("t2_frames", nfr - f0, 1);
    start = 1'b0;
    step();
    check("t2_done_drop", done, 0);
    check("t2_busy_drop", busy, 0);
    words[nfr[2:0]] = 16'h5A5A;
    start_and_wait(300, e);
    start = 1'b0;
    check("t2_new_value", value, 16'h5A5A);
    step();

    // 3: reset after bit 7 has been sampled.
    words[nfr[2:0]] = 16'h3C96;
    r0 = rises;
    start = 1'b1;
    e = 0;
    while ((rises - r0) < 8 && e < 300) begin
      @(negedge clk);
      #1;
      e = e + 1;
    end
    check("t3_reach_bit7", rises - r0, 8);
    rst   = 1'b1;
    start = 1'b0;
    step();
    check("t3_cs_n",  cs_n,  1);
    check("t3_sclk",  sclk,  0);
    check("t3_done",  done,  0);
    check("t3_value", value, 0);
    check("t3_busy",  busy,  0);
    rst = 1'b0;
    step();
    words[nfr[2:0]] = 16'h0F0F;
    start_and_wait(300, e);
    start = 1'b0;
    check("t3_clean_latency", e, 132);
    check("t3_clean_value", value, 16'h0F0F);
    step();

    // 4: 4 lead bits discarded, 12 data bits captured.
    start2 = 1'b1;
    @(posedge clk);
    wait_done(1, 300, e);
    start2 = 1'b0;
    check("t4_lead_value", value2, 16'h0ABC);
    check("t4_lead_latency", e, 132);
    step();

    // 5: single-cycle start pulse.
    words[nfr[2:0]] = 16'h6E01;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 300, e);
    check("t5_latency", e, 132);
    check("t5_value", value, 16'h6E01);
    hi = 1;
    repeat (10) begin
      step();
      if (done) hi = hi + 1;
    end
    check("t5_done_width", hi, 1);
    repeat (20) step();
    check("t5_value_held", value, 16'h6E01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
